// File: rtl/dtcm_arb_pkg.sv
// Shared constants and types for the DTCM port arbiter.
// The source tag records which requester owns the read data returning next cycle.
package dtcm_arb_pkg;

  typedef enum logic [1:0] {
    SRC_NONE = 2'd0,
    SRC_DATA = 2'd1,
    SRC_DMA  = 2'd2,
    SRC_AXI  = 2'd3
  } src_e;

  localparam int         DEFAULT_STARVE_LIMIT = 8;
  localparam logic [3:0] FULL_STRB            = 4'hF;

endpackage

// File: rtl/dtcm_arb_age_cnt.sv
// Saturating wait counter for one low-priority requester.
// promoted_o is asserted once the requester has been refused STARVE_LIMIT cycles in a row.
import dtcm_arb_pkg::*;

module dtcm_arb_age_cnt #(
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic clk,
  input  logic rst,
  input  logic req_i,
  input  logic grant_i,
  output logic promoted_o
);

  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);

  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (!req_i || grant_i) begin
      cnt_d = '0;
    end else if (cnt_q != LIMIT) begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign promoted_o = (cnt_q == LIMIT);

endmodule

// File: rtl/dtcm_arbiter.sv
// Three-way arbiter for the single DTCM SRAM port: core data, DMA and AXI bridge.
// Fixed priority data > DMA > AXI, with starving DMA/AXI promoted above data.
import dtcm_arb_pkg::*;

module dtcm_arbiter #(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = DEFAULT_STARVE_LIMIT
) (
  input  logic                    clk,
  input  logic                    rst,

  input  logic                    data_req,
  input  logic                    data_rd0_wr1,
  input  logic [DATA_WIDTH/8-1:0] data_byte_strobe,
  input  logic [ADDR_WIDTH-1:0]   data_addr,
  input  logic [DATA_WIDTH-1:0]   data_wdata,
  output logic                    data_ready,
  output logic                    data_rdata_valid,

  input  logic                    axi_req,
  input  logic                    axi_rd0_wr1,
  input  logic [DATA_WIDTH/8-1:0] axi_byte_strobe,
  input  logic [ADDR_WIDTH-1:0]   axi_addr,
  input  logic [DATA_WIDTH-1:0]   axi_wdata,
  output logic                    axi_ready,
  output logic                    axi_rdata_valid,

  input  logic                    dma_req,
  input  logic                    dma_rd0_wr1,
  input  logic [ADDR_WIDTH-1:0]   dma_addr,
  input  logic [DATA_WIDTH-1:0]   dma_wdata,
  output logic                    dma_ready,
  output logic                    dma_rdata_valid,

  output logic [DATA_WIDTH-1:0]   rdata,

  output logic                    mem_en,
  output logic                    mem_wen,
  output logic [ADDR_WIDTH-1:0]   mem_addr,
  output logic [DATA_WIDTH-1:0]   mem_wdata,
  output logic [DATA_WIDTH/8-1:0] mem_byte_strobe,
  input  logic [DATA_WIDTH-1:0]   mem_rdata
);

  localparam int STRB_W = DATA_WIDTH / 8;

  logic dma_prom, axi_prom;
  logic gnt_data, gnt_dma, gnt_axi;
  src_e src_d, src_q;

  dtcm_arb_age_cnt #(.STARVE_LIMIT(STARVE_LIMIT)) u_age_dma (
    .clk        (clk),
    .rst        (rst),
    .req_i      (dma_req),
    .grant_i    (gnt_dma),
    .promoted_o (dma_prom)
  );

  dtcm_arb_age_cnt #(.STARVE_LIMIT(STARVE_LIMIT)) u_age_axi (
    .clk        (clk),
    .rst        (rst),
    .req_i      (axi_req),
    .grant_i    (axi_req & gnt_axi),
    .promoted_o (axi_prom)
  );

  // A saturated count can outlive a withdrawn request by one cycle, so promotion is qualified by req.
  always_comb begin
    gnt_data = 1'b0;
    gnt_dma  = 1'b0;
    gnt_axi  = 1'b0;
    if (!rst) begin
      if (dma_req && dma_prom) begin
        gnt_dma = 1'b1;
      end else if (axi_req && axi_prom) begin
        gnt_axi = 1'b1;
      end else if (data_req) begin
        gnt_data = 1'b1;
      end else if (dma_req) begin
        gnt_dma = 1'b1;
      end else if (axi_req) begin
        gnt_axi = 1'b1;
      end
    end
  end

  assign data_ready = gnt_data;
  assign dma_ready  = gnt_dma;
  assign axi_ready  = gnt_axi;

  always_comb begin
    mem_en          = gnt_data | gnt_dma | gnt_axi;
    mem_wen         = 1'b0;
    mem_addr        = '0;
    mem_wdata       = '0;
    mem_byte_strobe = '0;
    src_d           = SRC_NONE;
    if (gnt_data) begin
      mem_wen         = data_rd0_wr1;
      mem_addr        = data_addr;
      mem_wdata       = data_wdata;
      mem_byte_strobe = data_byte_strobe;
      src_d           = data_rd0_wr1 ? SRC_NONE : SRC_DATA;
    end else if (gnt_dma) begin
      mem_wen         = dma_rd0_wr1;
      mem_addr        = dma_addr;
      mem_wdata       = dma_wdata;
      mem_byte_strobe = {(STRB_W/4){FULL_STRB}};
      src_d           = dma_rd0_wr1 ? SRC_NONE : SRC_DMA;
    end else if (gnt_axi) begin
      mem_wen         = axi_rd0_wr1;
      mem_addr        = axi_addr;
      mem_wdata       = axi_wdata;
      mem_byte_strobe = axi_byte_strobe;
      src_d           = axi_rd0_wr1 ? SRC_NONE : SRC_AXI;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q <= SRC_NONE;
    end else begin
      src_q <= src_d;
    end
  end

  assign data_rdata_valid = (src_q == SRC_DATA);
  assign dma_rdata_valid  = (src_q == SRC_DMA);
  assign axi_rdata_valid  = (src_q == SRC_AXI);
  assign rdata            = mem_rdata;

endmodule

// File: tb/tb_dtcm_arbiter.sv
// Self-checking bench for dtcm_arbiter: vector table, read-return scoreboard,
// and hand sequences for starvation promotion, withdrawal and reset.
module tb_dtcm_arbiter;
  import dtcm_arb_pkg::*;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int LIM = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          data_req, data_rd0_wr1, data_ready, data_rdata_valid;
  logic [3:0]    data_byte_strobe;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wdata;
  logic          axi_req, axi_rd0_wr1, axi_ready, axi_rdata_valid;
  logic [3:0]    axi_byte_strobe;
  logic [AW-1:0] axi_addr;
  logic [DW-1:0] axi_wdata;
  logic          dma_req, dma_rd0_wr1, dma_ready, dma_rdata_valid;
  logic [AW-1:0] dma_addr;
  logic [DW-1:0] dma_wdata;
  logic [DW-1:0] rdata, mem_wdata, mem_rdata;
  logic          mem_en, mem_wen;
  logic [AW-1:0] mem_addr;
  logic [3:0]    mem_byte_strobe;

  always #5 clk = ~clk;

  dtcm_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIM)) dut (
    .clk              (clk),
    .rst              (rst),
    .data_req         (data_req),
    .data_rd0_wr1     (data_rd0_wr1),
    .data_byte_strobe (data_byte_strobe),
    .data_addr        (data_addr),
    .data_wdata       (data_wdata),
    .data_ready       (data_ready),
    .data_rdata_valid (data_rdata_valid),
    .axi_req          (axi_req),
    .axi_rd0_wr1      (axi_rd0_wr1),
    .axi_byte_strobe  (axi_byte_strobe),
    .axi_addr         (axi_addr),
    .axi_wdata        (axi_wdata),
    .axi_ready        (axi_ready),
    .axi_rdata_valid  (axi_rdata_valid),
    .dma_req          (dma_req),
    .dma_rd0_wr1      (dma_rd0_wr1),
    .dma_addr         (dma_addr),
    .dma_wdata        (dma_wdata),
    .dma_ready        (dma_ready),
    .dma_rdata_valid  (dma_rdata_valid),
    .rdata            (rdata),
    .mem_en           (mem_en),
    .mem_wen          (mem_wen),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .mem_byte_strobe  (mem_byte_strobe),
    .mem_rdata        (mem_rdata)
  );

  typedef struct {
    logic        d_req, d_we, x_req, x_we, m_req, m_we;
    logic [2:0]  exp_rdy;   // {axi, dma, data}
    logic        exp_wen;
    logic [31:0] exp_addr;
    logic [31:0] exp_wdata;
    logic [3:0]  exp_strb;
  } vec_t;

  vec_t       vecs[9];
  int         checks = 0;
  int         errors = 0;
  logic [1:0] exp_q[$];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", name, got, exp);
    end
  endtask

  function automatic logic [2:0] src2v(input logic [1:0] s);
    case (s)
      2'd1:    return 3'b001;
      2'd2:    return 3'b010;
      2'd3:    return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  task automatic set_req(input logic dr, input logic dw, input logic xr, input logic xw,
                         input logic mr, input logic mw);
    data_req = dr; data_rd0_wr1 = dw;
    axi_req  = xr; axi_rd0_wr1  = xw;
    dma_req  = mr; dma_rd0_wr1  = mw;
  endtask

  // Called just after the driving negedge; returns on the next negedge.
  task automatic do_cycle(input logic [2:0] exp_rdy, input string name);
    logic [1:0] es;
    #2;
    chk({name, " ready"}, 64'({axi_ready, dma_ready, data_ready}), 64'(exp_rdy));
    chk({name, " mem_en"}, 64'(mem_en), 64'(|exp_rdy));
    es = SRC_NONE;
    if (exp_q.size() > 0) es = exp_q.pop_front();
    chk({name, " valid"}, 64'({axi_rdata_valid, dma_rdata_valid, data_rdata_valid}), 64'(src2v(es)));
    if (es != SRC_NONE) chk({name, " rdata"}, 64'(rdata), 64'(mem_rdata));
    if (exp_rdy[0])      exp_q.push_back(data_rd0_wr1 ? SRC_NONE : SRC_DATA);
    else if (exp_rdy[1]) exp_q.push_back(dma_rd0_wr1  ? SRC_NONE : SRC_DMA);
    else if (exp_rdy[2]) exp_q.push_back(axi_rd0_wr1  ? SRC_NONE : SRC_AXI);
    else                 exp_q.push_back(SRC_NONE);
    @(negedge clk);
  endtask

  initial begin
    vecs[0] = '{1,0, 0,0, 0,0, 3'b001, 0, 32'h40, 32'h0,         4'h0};
    vecs[1] = '{0,0, 0,0, 1,1, 3'b010, 1, 32'h80, 32'h1234_5678, 4'hF};
    vecs[2] = '{0,0, 1,0, 0,0, 3'b100, 0, 32'hA0, 32'h0,         4'h0};
    vecs[3] = '{0,0, 1,1, 0,0, 3'b100, 1, 32'hA0, 32'h2222_0000, 4'hC};
    vecs[4] = '{1,1, 0,0, 1,0, 3'b001, 1, 32'h40, 32'h1111_0000, 4'h3};
    vecs[5] = '{0,0, 1,1, 1,0, 3'b010, 0, 32'h80, 32'h0,         4'h0};
    vecs[6] = '{1,0, 1,0, 1,0, 3'b001, 0, 32'h40, 32'h0,         4'h0};
    vecs[7] = '{0,0, 0,0, 0,0, 3'b000, 0, 32'h0,  32'h0,         4'h0};
    vecs[8] = '{0,0, 1,1, 1,1, 3'b010, 1, 32'h80, 32'h1234_5678, 4'hF};

    data_addr = 32'h40; data_wdata = 32'h1111_0000; data_byte_strobe = 4'h3;
    axi_addr  = 32'hA0; axi_wdata  = 32'h2222_0000; axi_byte_strobe  = 4'hC;
    dma_addr  = 32'h80; dma_wdata  = 32'h1234_5678;
    mem_rdata = 32'hDEAD_BEEF;

    // reset gates grants even with every requester active
    rst = 1'b1;
    set_req(1, 0, 1, 0, 1, 0);
    @(negedge clk);
    #2;
    chk("rst ready", 64'({axi_ready, dma_ready, data_ready}), 64'(3'b000));
    chk("rst mem_en", 64'(mem_en), 64'(0));
    chk("rst valid", 64'({axi_rdata_valid, dma_rdata_valid, data_rdata_valid}), 64'(3'b000));
    @(negedge clk);
    rst = 1'b0;
    set_req(0, 0, 0, 0, 0, 0);
    do_cycle(3'b000, "idle0");

    // vector table, each access followed by an idle cycle carrying its read return
    for (int i = 0; i < 9; i++) begin
      set_req(vecs[i].d_req, vecs[i].d_we, vecs[i].x_req, vecs[i].x_we, vecs[i].m_req, vecs[i].m_we);
      #1;
      if (vecs[i].exp_rdy != 3'b000) begin
        chk($sformatf("vec%0d wen", i), 64'(mem_wen), 64'(vecs[i].exp_wen));
        chk($sformatf("vec%0d addr", i), 64'(mem_addr), 64'(vecs[i].exp_addr));
        if (vecs[i].exp_wen) begin
          chk($sformatf("vec%0d wdata", i), 64'(mem_wdata), 64'(vecs[i].exp_wdata));
          chk($sformatf("vec%0d strb", i), 64'(mem_byte_strobe), 64'(vecs[i].exp_strb));
        end
      end
      do_cycle(vecs[i].exp_rdy, $sformatf("vec%0d", i));
      set_req(0, 0, 0, 0, 0, 0);
      mem_rdata = 32'hDEAD_BEEF + 32'(i);
      do_cycle(3'b000, $sformatf("vec%0d ret", i));
    end

    // uncontested DMA leaves its counter at zero
    set_req(0, 0, 0, 0, 1, 0);
    do_cycle(3'b010, "dma alone");
    set_req(0, 0, 0, 0, 0, 0);
    #1;
    chk("dma alone cnt", 64'(dut.u_age_dma.cnt_q), 64'(0));
    do_cycle(3'b000, "dma alone ret");

    // back-to-back reads from different requesters
    mem_rdata = 32'h0;
    set_req(1, 0, 0, 0, 0, 0); do_cycle(3'b001, "pipe data");
    mem_rdata = 32'hDEAD_BEEF;
    set_req(0, 0, 1, 0, 0, 0); do_cycle(3'b100, "pipe axi");
    mem_rdata = 32'hA5A5_0001;
    set_req(0, 0, 0, 0, 1, 0); do_cycle(3'b010, "pipe dma");
    mem_rdata = 32'h5A5A_0002;
    set_req(0, 0, 0, 0, 0, 0); do_cycle(3'b000, "pipe end");
    do_cycle(3'b000, "pipe idle");

    // continuous contention: data x8, DMA, AXI, data
    set_req(1, 0, 1, 0, 1, 0);
    for (int c = 0; c < 11; c++) begin
      mem_rdata = 32'hC000_0000 + 32'(c);
      if (c == 8) begin
        #1;
        chk("cont dma cnt sat", 64'(dut.u_age_dma.cnt_q), 64'(LIM));
        chk("cont axi cnt sat", 64'(dut.u_age_axi.cnt_q), 64'(LIM));
      end
      if (c == 9) begin
        #1;
        chk("cont dma cnt clr", 64'(dut.u_age_dma.cnt_q), 64'(0));
      end
      if (c == 10) begin
        #1;
        chk("cont axi cnt clr", 64'(dut.u_age_axi.cnt_q), 64'(0));
      end
      do_cycle(c < 8 ? 3'b001 : (c == 8 ? 3'b010 : (c == 9 ? 3'b100 : 3'b001)),
               $sformatf("cont%0d", c));
    end
    set_req(0, 0, 0, 0, 0, 0);
    do_cycle(3'b000, "cont end");
    do_cycle(3'b000, "cont idle");

    // AXI withdraws at age 5, then must wait a full LIMIT again
    set_req(1, 0, 1, 0, 0, 0);
    for (int c = 0; c < 5; c++) do_cycle(3'b001, $sformatf("wd%0d", c));
    #1;
    chk("wd cnt 5", 64'(dut.u_age_axi.cnt_q), 64'(5));
    set_req(1, 0, 0, 0, 0, 0);
    do_cycle(3'b001, "wd drop");
    #1;
    chk("wd cnt clr", 64'(dut.u_age_axi.cnt_q), 64'(0));
    set_req(1, 0, 1, 0, 0, 0);
    for (int c = 0; c < 9; c++) do_cycle(c < 8 ? 3'b001 : 3'b100, $sformatf("wd re%0d", c));
    set_req(0, 0, 0, 0, 0, 0);
    do_cycle(3'b000, "wd end");

    // reset right after a granted AXI read suppresses its return
    set_req(1, 0, 1, 0, 1, 0);
    for (int c = 0; c < 9; c++) do_cycle(c < 8 ? 3'b001 : 3'b010, $sformatf("rr%0d", c));
    #2;
    chk("rr axi ready", 64'({axi_ready, dma_ready, data_ready}), 64'(3'b100));
    @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    #2;
    chk("rr valid", 64'({axi_rdata_valid, dma_rdata_valid, data_rdata_valid}), 64'(3'b000));
    chk("rr ready gated", 64'({axi_ready, dma_ready, data_ready}), 64'(3'b000));
    @(negedge clk);
    rst = 1'b0;
    set_req(0, 0, 0, 0, 0, 0);
    #1;
    chk("rr dma cnt", 64'(dut.u_age_dma.cnt_q), 64'(0));
    chk("rr axi cnt", 64'(dut.u_age_axi.cnt_q), 64'(0));
    do_cycle(3'b000, "rr post0");
    do_cycle(3'b000, "rr post1");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
